// File: rtl/control_unit.sv
// Instruction sequencer: latches a 9-bit instruction from DIN and steps through
// T0..T3 driving the bus-mux selects and the register/A/G/IR load enables.
module control_unit #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9,
  parameter int SEL_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              IRin,
  output logic [SEL_W-1:0]  Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic [SEL_W-1:0]  selectR,
  output logic              selectG,
  output logic              selectDin,
  output logic              Done,
  output logic [1:0]        tstep,
  output logic [IR_W-1:0]   ir
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_t;

  localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

  tstep_t     state;
  logic [2:0] opcode;
  logic [2:0] x_idx;
  logic [2:0] y_idx;
  logic       is_arith;
  logic       unused_din;

  assign opcode     = ir[IR_W-1 -: 3];
  assign x_idx      = ir[5:3];
  assign y_idx      = ir[2:0];
  assign is_arith   = (opcode == 3'b010) || (opcode == 3'b011);
  assign tstep      = state;
  // Only the low IR_W bits of DIN form an instruction; the rest is immediate data.
  assign unused_din = ^DIN[DATA_W-1:IR_W];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      unique case (state)
        T0: if (Run) begin
          ir    <= DIN[IR_W-1:0];
          state <= T1;
        end
        T1: state <= is_arith ? T2 : T0;
        T2: state <= T3;
        T3: state <= T0;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    IRin      = 1'b0;
    Rin       = '0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AddSub    = 1'b0;
    selectR   = '0;
    selectG   = 1'b0;
    selectDin = 1'b0;
    Done      = 1'b0;
    if (!Reset) begin
      unique case (state)
        T0: IRin = Run;
        T1: begin
          unique case (opcode)
            3'b000: begin
              selectR = SEL_W'(y_idx);
              Rin     = ONE << x_idx;
              Done    = 1'b1;
            end
            3'b001: begin
              selectDin = 1'b1;
              Rin       = ONE << x_idx;
              Done      = 1'b1;
            end
            3'b010, 3'b011: begin
              selectR = SEL_W'(x_idx);
              Ain     = 1'b1;
            end
            default: Done = 1'b1;
          endcase
        end
        T2: begin
          selectR = SEL_W'(y_idx);
          Gin     = 1'b1;
          AddSub  = (opcode == 3'b011);
        end
        T3: begin
          // selectR stays 0 while G owns the bus.
          selectG = 1'b1;
          Rin     = ONE << x_idx;
          Done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-cycle vector table of inputs and expected
// outputs/state, plus hand-written latency sequences.
module tb_control_unit;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic        IRin;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic [7:0]  selectR;
  logic        selectG;
  logic        selectDin;
  logic        Done;
  logic [1:0]  tstep;
  logic [8:0]  ir;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
    .IRin(IRin), .Rin(Rin), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
    .selectR(selectR), .selectG(selectG), .selectDin(selectDin),
    .Done(Done), .tstep(tstep), .ir(ir)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Packed view: {IRin, Rin, Ain, Gin, AddSub, selectR, selectG, selectDin, Done, tstep, ir}
  typedef struct {
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic [33:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [33:0] pack_out(
    input logic irin, input logic [7:0] rin, input logic ain, input logic gin,
    input logic addsub, input logic [7:0] selr, input logic selg,
    input logic seld, input logic done, input logic [1:0] ts, input logic [8:0] irv);
    return {irin, rin, ain, gin, addsub, selr, selg, seld, done, ts, irv};
  endfunction

  task automatic add_vec(input logic r, input logic run, input logic [15:0] din,
                         input logic [33:0] exp);
    vec_t v;
    v.reset = r; v.run = run; v.din = din; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string name, input logic [33:0] exp);
    logic [33:0] act;
    act = {IRin, Rin, Ain, Gin, AddSub, selectR, selectG, selectDin, Done, tstep, ir};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
    checks++;
    if ((selectG && selectDin) || ((selectG || selectDin) && selectR != 8'h00)) begin
      errors++;
      $display("FAIL %s invariant: selectG=%b selectDin=%b selectR=%h expected exclusive with selectR=0",
               name, selectG, selectDin, selectR);
    end
  endtask

  task automatic drive(input logic r, input logic run, input logic [15:0] din);
    @(posedge Clock);
    #1;
    Reset = r;
    Run   = run;
    DIN   = din;
  endtask

  // Counts cycles after the IR-load edge until Done, with a bounded wait.
  task automatic run_latency(input string name, input logic [15:0] din, input int exp_cyc);
    int got;
    got = -1;
    drive(1'b0, 1'b1, din);
    for (int n = 1; n <= 8; n++) begin
      drive(1'b0, 1'b0, 16'h0000);
      @(negedge Clock);
      if (Done) begin
        got = n;
        break;
      end
    end
    checks++;
    if (got != exp_cyc) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, got, exp_cyc);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = 16'h0000;

    // Reset with Run held high must not produce IRin.
    add_vec(1, 1, 16'h0015, pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h000));
    for (int i = 0; i < 5; i++)
      add_vec(0, 0, 16'h0015, pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h000));
    // mv R2,R5
    add_vec(0, 1, 16'h0015, pack_out(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h000));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h04, 0, 0, 0, 8'h05, 0, 0, 1, 2'd1, 9'h015));
    // mvi R1 with immediate 1234; Run in T1 is ignored
    add_vec(0, 1, 16'h0048, pack_out(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h015));
    add_vec(0, 1, 16'h1234, pack_out(0, 8'h02, 0, 0, 0, 8'h00, 0, 1, 1, 2'd1, 9'h048));
    // sub R3,R2 back-to-back after mvi
    add_vec(0, 1, 16'h00DA, pack_out(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h048));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h00, 1, 0, 0, 8'h03, 0, 0, 0, 2'd1, 9'h0DA));
    add_vec(0, 1, 16'h01FF, pack_out(0, 8'h00, 0, 1, 1, 8'h02, 0, 0, 0, 2'd2, 9'h0DA));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h08, 0, 0, 0, 8'h00, 1, 0, 1, 2'd3, 9'h0DA));
    // add R0,R7 with reset during T2
    add_vec(0, 1, 16'h0087, pack_out(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h0DA));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 2'd1, 9'h087));
    add_vec(1, 0, 16'h0000, pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd2, 9'h087));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h000));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h000));
    // nop (111), then back-to-back mv R2,R5
    add_vec(0, 1, 16'h01FF, pack_out(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h000));
    add_vec(0, 1, 16'h0015, pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 2'd1, 9'h1FF));
    add_vec(0, 1, 16'h0015, pack_out(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h1FF));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h04, 0, 0, 0, 8'h05, 0, 0, 1, 2'd1, 9'h015));
    // add R1,R1 (X==Y, AddSub=0)
    add_vec(0, 1, 16'h0089, pack_out(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h015));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h00, 1, 0, 0, 8'h01, 0, 0, 0, 2'd1, 9'h089));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h00, 0, 1, 0, 8'h01, 0, 0, 0, 2'd2, 9'h089));
    add_vec(0, 0, 16'h0000, pack_out(0, 8'h02, 0, 0, 0, 8'h00, 1, 0, 1, 2'd3, 9'h089));
    add_vec(0, 0, 16'h00DA, pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h089));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].reset, vecs[i].run, vecs[i].din);
      @(negedge Clock);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp);
    end

    run_latency("mvi_r7", 16'h0078, 1);
    run_latency("sub_r3_r2", 16'h00DA, 3);
    run_latency("nop_100", 16'h0100, 1);
    run_latency("mv_r3_r3", 16'h001B, 1);

    // Reset during T3 suppresses the write-back and Done.
    drive(0, 1, 16'h00D1);
    drive(0, 0, 16'h0000);
    drive(0, 0, 16'h0000);
    drive(1, 0, 16'h0000);
    @(negedge Clock);
    check_outputs("reset_in_t3", pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd3, 9'h0D1));
    drive(0, 0, 16'h0000);
    @(negedge Clock);
    check_outputs("after_reset_t3", pack_out(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 9'h000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
